// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle CPU main control FSM.
// Optional feature macro: MC_IMM_OPS_EN (ADDI/ORI immediate path).
package mc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_EXECUTE   = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_IMM_EXEC  = 4'd11,
    ST_IMM_WB    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OPC   = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // DECODE successor; ST_FETCH doubles as the "illegal opcode" answer.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    nxt = ST_FETCH;
    case (op)
      OP_RTYPE:      nxt = ST_EXECUTE;
      OP_LW, OP_SW:  nxt = ST_MEM_ADDR;
      OP_BEQ:        nxt = ST_BRANCH;
      OP_J:          nxt = ST_JUMP;
`ifdef MC_IMM_OPS_EN
      OP_ADDI, OP_ORI: nxt = ST_IMM_EXEC;
`endif
      default:       nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle CPU: Moore outputs decoded from the state register.
// Optional feature macro: MC_IMM_OPS_EN adds the IMM_EXEC/IMM_WB path for ADDI/ORI.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int OPCODE_W  = 6,
  parameter int ALUSRCB_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OPCODE_W-1:0]  opcode,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic [1:0]           PCSource,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [ALUSRCB_W-1:0] ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic                 retire,
  output logic                 illegal_op,
  output state_t               dbg_state
);

  state_t state_q, state_d;
  logic   op_legal;

  assign dbg_state = state_q;
  assign op_legal  = (decode_next(opcode) != ST_FETCH);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:      state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_DECODE;
      ST_DECODE:    state_d = decode_next(opcode);
      // The opcode is held in IR, so LW/SW is re-judged here.
      ST_MEM_ADDR:  state_d = (opcode == OP_LW) ? ST_MEM_READ :
                              (opcode == OP_SW) ? ST_MEM_WRITE : ST_FETCH;
      ST_MEM_READ:  state_d = ST_MEM_WB;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WRITE: state_d = ST_FETCH;
      ST_EXECUTE:   state_d = ST_R_WB;
      ST_R_WB:      state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
`ifdef MC_IMM_OPS_EN
      ST_IMM_EXEC:  state_d = ST_IMM_WB;
      ST_IMM_WB:    state_d = ST_FETCH;
`endif
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = PCSRC_ALU;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = ALUSRCB_W'(SRCB_REG);
    ALUOp       = ALUOP_ADD;
    retire      = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = ALUSRCB_W'(SRCB_FOUR);
      end
      ST_DECODE: begin
        ALUSrcB    = ALUSRCB_W'(SRCB_IMMSH);
        illegal_op = !op_legal;
      end
      ST_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_W'(SRCB_IMM);
      end
      ST_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      ST_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = 1'b1;
      end
      ST_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        retire      = 1'b1;
      end
      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        retire   = 1'b1;
      end
`ifdef MC_IMM_OPS_EN
      ST_IMM_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_W'(SRCB_IMM);
        ALUOp   = ALUOP_OPC;
      end
      ST_IMM_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected state and control word from an expected queue.
module tb_multicycle_control;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, retire, illegal_op;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  state_t     dbg_state;

  int total = 0;
  int bad   = 0;

  // Expected entries: {state[3:0], control word[17:0]}.
  logic [21:0] exp_q[$];

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .retire(retire), .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  function automatic logic [17:0] ctrl_word();
    return {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, retire, illegal_op};
  endfunction

  function automatic logic [17:0] mk(
    input logic pcw, input logic pcwc, input logic [1:0] pcs, input logic iord,
    input logic mr, input logic mw, input logic irw, input logic m2r, input logic rd,
    input logic rw, input logic asa, input logic [1:0] asb, input logic [1:0] aop,
    input logic ret, input logic ill);
    return {pcw, pcwc, pcs, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ret, ill};
  endfunction

  // Hand-derived control words per state.
  logic [17:0] c_idle, c_fetch, c_dec, c_dec_ill, c_maddr, c_mrd, c_mwb, c_mwr;
  logic [17:0] c_exe, c_rwb, c_br, c_jmp, c_iexe, c_iwb;

  initial begin
    c_idle    = '0;
    c_fetch   = mk(1,0,2'b00,0, 1,0,1,0,0, 0,0,2'b01,2'b00,0,0);
    c_dec     = mk(0,0,2'b00,0, 0,0,0,0,0, 0,0,2'b11,2'b00,0,0);
    c_dec_ill = mk(0,0,2'b00,0, 0,0,0,0,0, 0,0,2'b11,2'b00,0,1);
    c_maddr   = mk(0,0,2'b00,0, 0,0,0,0,0, 0,1,2'b10,2'b00,0,0);
    c_mrd     = mk(0,0,2'b00,1, 1,0,0,0,0, 0,0,2'b00,2'b00,0,0);
    c_mwb     = mk(0,0,2'b00,0, 0,0,0,1,0, 1,0,2'b00,2'b00,1,0);
    c_mwr     = mk(0,0,2'b00,1, 0,1,0,0,0, 0,0,2'b00,2'b00,1,0);
    c_exe     = mk(0,0,2'b00,0, 0,0,0,0,0, 0,1,2'b00,2'b10,0,0);
    c_rwb     = mk(0,0,2'b00,0, 0,0,0,0,1, 1,0,2'b00,2'b00,1,0);
    c_br      = mk(0,1,2'b01,0, 0,0,0,0,0, 0,1,2'b00,2'b01,1,0);
    c_jmp     = mk(1,0,2'b10,0, 0,0,0,0,0, 0,0,2'b00,2'b00,1,0);
    c_iexe    = mk(0,0,2'b00,0, 0,0,0,0,0, 0,1,2'b10,2'b11,0,0);
    c_iwb     = mk(0,0,2'b00,0, 0,0,0,0,0, 1,0,2'b00,2'b00,1,0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input state_t s, input logic [17:0] c);
    exp_q.push_back({s, c});
  endtask

  // Each popped entry is one clock: advance, then compare state and control word.
  task automatic drain(input string tag);
    logic [21:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step();
      check({tag, ".state"}, 32'(dbg_state), 32'(e[21:18]));
      check({tag, ".ctrl"}, 32'(ctrl_word()), 32'(e[17:0]));
      check({tag, ".excl"}, {30'd0, PCWrite & PCWriteCond, MemRead & MemWrite}, 32'd0);
    end
  endtask

  // Called while in FETCH; ends back in the next FETCH.
  task automatic run_instr(input string tag, input logic [5:0] op);
    opcode = op;
    case (op)
      OP_LW: begin
        push(ST_DECODE, c_dec); push(ST_MEM_ADDR, c_maddr);
        push(ST_MEM_READ, c_mrd); push(ST_MEM_WB, c_mwb);
      end
      OP_SW: begin
        push(ST_DECODE, c_dec); push(ST_MEM_ADDR, c_maddr); push(ST_MEM_WRITE, c_mwr);
      end
      OP_RTYPE: begin
        push(ST_DECODE, c_dec); push(ST_EXECUTE, c_exe); push(ST_R_WB, c_rwb);
      end
      OP_BEQ: begin push(ST_DECODE, c_dec); push(ST_BRANCH, c_br); end
      OP_J:   begin push(ST_DECODE, c_dec); push(ST_JUMP, c_jmp); end
`ifdef MC_IMM_OPS_EN
      OP_ADDI, OP_ORI: begin
        push(ST_DECODE, c_dec); push(ST_IMM_EXEC, c_iexe); push(ST_IMM_WB, c_iwb);
      end
`endif
      default: push(ST_DECODE, c_dec_ill);
    endcase
    push(ST_FETCH, c_fetch);
    drain(tag);
  endtask

  initial begin
    reset  = 1'b0;
    opcode = 6'b000000;
    #2;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst.state", 32'(dbg_state), 32'(ST_IDLE));
      check("rst.ctrl", 32'(ctrl_word()), 32'(c_idle));
    end
    reset = 1'b1;
    push(ST_FETCH, c_fetch);
    drain("release");

    run_instr("lw", OP_LW);
    run_instr("rtype", OP_RTYPE);
    run_instr("sw", OP_SW);
    run_instr("beq", OP_BEQ);
    run_instr("j", OP_J);
    run_instr("ill3f", 6'b111111);
    run_instr("ill01", 6'b000001);
    run_instr("addi", OP_ADDI);
    run_instr("ori", OP_ORI);
    run_instr("lw2", OP_LW);

    // Reset asserted while in MEM_READ.
    opcode = OP_LW;
    push(ST_DECODE, c_dec); push(ST_MEM_ADDR, c_maddr); push(ST_MEM_READ, c_mrd);
    drain("midrst");
    reset = 1'b0;
    step();
    check("midrst.state", 32'(dbg_state), 32'(ST_IDLE));
    check("midrst.memread", 32'(MemRead), 32'd0);
    check("midrst.ctrl", 32'(ctrl_word()), 32'(c_idle));
    reset = 1'b1;
    push(ST_FETCH, c_fetch);
    drain("refetch");
    run_instr("beq2", OP_BEQ);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle CPU. Sequences fetch/decode/execute/memory/writeback one step per clock. Drives the ProgramCounter enables (PCWrite, PCWriteCond, PCSource), memory, IR, register file and ALU mux selects. Outputs are Moore-decoded from the state register; the only input is the opcode field of the instruction register.

Parameters:
OPCODE_W, 6, opcode field width.
ALUSRCB_W, 2, width of the ALU B-operand select.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset (sampled on rising clk edge, 0 = reset).
opcode  input  6  IR[31:26], stable from the cycle after FETCH.
PCWrite  output  1  unconditional PC load.
PCWriteCond  output  1  PC load if ALU Zero (gated externally).
PCSource  output  2  PC input select: 00 ALU result, 01 ALUOut, 10 jump target.
IorD  output  1  memory address select: 0 PC, 1 ALUOut.
MemRead  output  1  memory read strobe.
MemWrite  output  1  memory write strobe.
IRWrite  output  1  IR load.
MemtoReg  output  1  register write data: 0 ALUOut, 1 MDR.
RegDst  output  1  destination: 0 rt, 1 rd.
RegWrite  output  1  register file write.
ALUSrcA  output  1  0 PC, 1 A.
ALUSrcB  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
ALUOp  output  2  00 add, 01 sub, 10 funct, 11 opcode-decoded.
retire  output  1  high in the final cycle of each instruction.
illegal_op  output  1  high in DECODE when the opcode is unsupported.

Behaviour:
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, BRANCH, JUMP, IMM_EXEC, IMM_WB.
- Reset: reset==0 at a clk edge forces IDLE regardless of state, including mid-instruction. In IDLE all outputs are 0. The first clock edge with reset==1 moves to FETCH.
- Every signal not listed for a state is 0.
- FETCH: MemRead, IRWrite, PCWrite; ALUSrcB=01. Next state: DECODE.
- DECODE: ALUSrcB=11.
  - Next state by opcode: 000000 -> EXECUTE; 100011 (LW) or 101011 (SW) -> MEM_ADDR; 000100 (BEQ) -> BRANCH; 000010 (J) -> JUMP; 001000 (ADDI) or 001101 (ORI) -> IMM_EXEC when the optional feature is enabled.
  - Any other opcode: illegal_op=1 and next state FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10. Next: MEM_READ for LW, MEM_WRITE for SW, judged on the held opcode.
- MEM_READ: MemRead, IorD. Next: MEM_WB.
- MEM_WB: RegWrite, MemtoReg, retire. Next: FETCH.
- MEM_WRITE: MemWrite, IorD, retire. Next: FETCH.
- EXECUTE: ALUSrcA=1, ALUOp=10. Next: R_WB.
- R_WB: RegDst, RegWrite, retire. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond, PCSource=01, retire. Next: FETCH.
- JUMP: PCWrite, PCSource=10, retire. Next: FETCH.
- IMM_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Next: IMM_WB.
- IMM_WB: RegWrite (RegDst=0, MemtoReg=0), retire. Next: FETCH.
- Latency in cycles, FETCH to retire inclusive: LW 5; SW, R-type, ADDI/ORI 4; BEQ, J 3; illegal 2 with no retire.
- PCWrite and PCWriteCond are never high in the same cycle. MemRead and MemWrite are never high in the same cycle.
- Unreachable state encodings fall through to IDLE on the next edge.

Optional Feature:
- Macro MC_IMM_OPS_EN.
- Defined: ADDI/ORI decode to IMM_EXEC/IMM_WB.
- Undefined: IMM_EXEC/IMM_WB are not built, ADDI/ORI are treated as illegal, and ALUOp never takes the value 11.

Decomposition:
- Shared package mc_pkg holds:
  - the state enum, 4-bit encoding;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI;
  - ALUOp, ALUSrcB and PCSource encodings.
- Single module: a state register plus two combinational blocks (next-state and output decode). No sub-module.

Test Plan:
- Hold reset=0 for 3 cycles -> all outputs 0, state IDLE. Release -> FETCH next cycle with MemRead=IRWrite=PCWrite=1, ALUSrcB=01.
- opcode=100011 (LW) -> FETCH, DECODE, MEM_ADDR, MEM_READ (IorD=1), MEM_WB (RegWrite=MemtoReg=1, retire=1), then FETCH; 5 cycles.
- opcode=000000, then 101011 back to back -> R_WB with RegDst=1 in cycle 4; SW retires in cycle 8 with MemWrite=1, IorD=1.
- opcode=000100, then 000010 -> BRANCH (PCWriteCond=1, PCSource=01, ALUOp=01) in cycle 3; JUMP (PCWrite=1, PCSource=10) in cycle 6.
- opcode=111111 -> illegal_op=1 in DECODE, retire never asserted, FETCH next cycle. opcode=001000 -> IMM path with MC_IMM_OPS_EN defined, illegal without it.
- reset=0 asserted during MEM_READ -> IDLE on that edge, MemRead=0 the same cycle after the edge; after release, a fresh FETCH.
